// File: rtl/resp_compactor.sv
// resp_compactor: MISR-based response compactor. Folds NUMBER_OF_TESTS
// response words from a circuit under test into a signature and compares
// the result against a golden signature captured at start.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting responses, resp_ready=1
// DONE  | run complete, done/pass held until next start
module resp_compactor #(
  parameter int                    OUTPUT_WIDTH    = 7,
  parameter int                    NUMBER_OF_TESTS = 10000,
  parameter int                    SIG_WIDTH       = 16,
  parameter logic [SIG_WIDTH-1:0]  POLY            = 16'h1021,
  parameter logic [SIG_WIDTH-1:0]  SEED            = 16'h0000
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic [SIG_WIDTH-1:0]                     golden_sig,
  input  logic                                     resp_valid,
  input  logic [OUTPUT_WIDTH-1:0]                  resp,
  output logic                                     resp_ready,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     pass,
  output logic [SIG_WIDTH-1:0]                     signature,
  output logic [$clog2(NUMBER_OF_TESTS+1)-1:0]     count
);

  localparam int CNT_W = $clog2(NUMBER_OF_TESTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUMBER_OF_TESTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SIG_WIDTH-1:0]  r_sig;
  logic [SIG_WIDTH-1:0]  r_golden;
  logic [CNT_W-1:0]      r_count;
  logic                  r_done;
  logic                  r_pass;

  logic                  w_start;
  logic                  w_accept;
  logic                  w_last;
  logic [CNT_W-1:0]      w_count_inc;
  logic [SIG_WIDTH-1:0]  w_sig_next;

  // Start is only honoured outside RUN; a response is only taken in RUN,
  // so a start coinciding with resp_valid never consumes that word.
  assign w_start     = start && (r_state != RUN);
  assign w_accept    = resp_valid && (r_state == RUN);
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last      = w_accept && (w_count_inc == LAST_CNT);

  // Shift left, fold the outgoing MSB back through the polynomial, mix in
  // the zero-extended response word.
  assign w_sig_next = {r_sig[SIG_WIDTH-2:0], 1'b0}
                    ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
                    ^ SIG_WIDTH'(resp);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Signature, count, golden capture and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig    <= SEED;
      r_golden <= '0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_start) begin
      r_sig    <= SEED;
      r_golden <= golden_sig;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_accept) begin
      r_sig   <= w_sig_next;
      r_count <= w_count_inc;
      if (w_last) begin
        r_done <= 1'b1;
        r_pass <= (w_sig_next == r_golden);
      end
    end
  end

  assign resp_ready = (r_state == RUN);
  assign busy       = (r_state == RUN);
  assign done       = r_done;
  assign pass       = r_pass;
  assign signature  = r_sig;
  assign count      = r_count;

endmodule

// File: tb/tb_resp_compactor.sv
// Testbench for resp_compactor: three instances cover a two-word run, a
// single-word run with a non-zero seed, and the full default-size run.
module tb_resp_compactor;

  logic        clk;
  logic        rst_n;
  logic [15:0] golden;
  logic        resp_valid;
  logic [6:0]  resp;
  logic        start_a, start_b, start_c;

  logic        a_ready, a_busy, a_done, a_pass;
  logic [15:0] a_sig;
  logic [1:0]  a_cnt;
  logic        b_ready, b_busy, b_done, b_pass;
  logic [15:0] b_sig;
  logic [0:0]  b_cnt;
  logic        c_ready, c_busy, c_done, c_pass;
  logic [15:0] c_sig;
  logic [13:0] c_cnt;

  int n_pass  = 0;
  int n_total = 0;

  resp_compactor #(.NUMBER_OF_TESTS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .golden_sig(golden),
    .resp_valid(resp_valid), .resp(resp), .resp_ready(a_ready),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig), .count(a_cnt));

  resp_compactor #(.NUMBER_OF_TESTS(1), .SEED(16'h8000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .golden_sig(golden),
    .resp_valid(resp_valid), .resp(resp), .resp_ready(b_ready),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .count(b_cnt));

  resp_compactor dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .golden_sig(golden),
    .resp_valid(resp_valid), .resp(resp), .resp_ready(c_ready),
    .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig), .count(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: multiply signature by x modulo (x^16 + 0x1021), add response.
  function automatic int misr_model(input int s, input int w);
    int t;
    t = s * 2;
    if (t >= 65536) t = (t - 65536) ^ 'h1021;
    return t ^ w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    golden  = 16'h1234;
    start_a = 1'b1;
    tick();
    start_a    = 1'b0;
    resp_valid = 1'b1;
    resp       = 7'h5a;
    tick();
    resp_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({a_busy, a_ready, a_done, a_pass, a_cnt, a_sig} !== {4'b0000, 2'd0, 16'h0000}) begin
      $display("FAIL reset_a: got busy/ready/done/pass=%b%b%b%b cnt=%0d sig=%h, want 0000 cnt=0 sig=0000",
               a_busy, a_ready, a_done, a_pass, a_cnt, a_sig);
    end else n_pass++;
    n_total++;
    if ({b_busy, b_done, b_sig} !== {2'b00, 16'h8000}) begin
      $display("FAIL reset_seed_b: got busy=%b done=%b sig=%h, want 0 0 8000", b_busy, b_done, b_sig);
    end else n_pass++;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    golden  = 16'h0002;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    golden  = 16'($urandom);
    n_total++;
    if ({a_busy, a_ready, a_done, a_cnt, a_sig} !== {3'b110, 2'd0, 16'h0000}) begin
      $display("FAIL start_after_reset: got busy=%b ready=%b done=%b cnt=%0d sig=%h, want 1 1 0 0 0000",
               a_busy, a_ready, a_done, a_cnt, a_sig);
    end else n_pass++;
    resp_valid = 1'b1;
    resp       = 7'h01;
    tick();
    n_total++;
    if ({a_done, a_cnt, a_sig} !== {1'b0, 2'd1, 16'h0001}) begin
      $display("FAIL basic_first: got done=%b cnt=%0d sig=%h, want 0 1 0001", a_done, a_cnt, a_sig);
    end else n_pass++;
    resp = 7'h00;
    tick();
    resp_valid = 1'b0;
    n_total++;
    if ({a_done, a_pass, a_busy, a_ready, a_cnt, a_sig} !== {4'b1100, 2'd2, 16'h0002}) begin
      $display("FAIL basic_done: got done=%b pass=%b busy=%b ready=%b cnt=%0d sig=%h, want 1 1 0 0 2 0002",
               a_done, a_pass, a_busy, a_ready, a_cnt, a_sig);
    end else n_pass++;
  endtask

  task automatic test_fail_hold();
    golden     = 16'h0003;
    start_a    = 1'b1;
    resp_valid = 1'b1;
    resp       = 7'h55;
    tick();
    start_a = 1'b0;
    n_total++;
    if ({a_busy, a_done, a_cnt, a_sig} !== {2'b10, 2'd0, 16'h0000}) begin
      $display("FAIL start_with_valid: got busy=%b done=%b cnt=%0d sig=%h, want 1 0 0 0000",
               a_busy, a_done, a_cnt, a_sig);
    end else n_pass++;
    resp    = 7'h01;
    start_a = 1'b1;
    golden  = 16'h0002;
    tick();
    start_a = 1'b0;
    n_total++;
    if ({a_busy, a_cnt, a_sig} !== {1'b1, 2'd1, 16'h0001}) begin
      $display("FAIL start_ignored_in_run: got busy=%b cnt=%0d sig=%h, want 1 1 0001", a_busy, a_cnt, a_sig);
    end else n_pass++;
    resp = 7'h00;
    tick();
    n_total++;
    if ({a_done, a_pass, a_cnt, a_sig} !== {2'b10, 2'd2, 16'h0002}) begin
      $display("FAIL fail_done: got done=%b pass=%b cnt=%0d sig=%h, want 1 0 2 0002", a_done, a_pass, a_cnt, a_sig);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin
      resp = 7'($urandom);
      tick();
    end
    resp_valid = 1'b0;
    n_total++;
    if ({a_done, a_pass, a_ready, a_cnt, a_sig} !== {3'b100, 2'd2, 16'h0002}) begin
      $display("FAIL done_hold: got done=%b pass=%b ready=%b cnt=%0d sig=%h, want 1 0 0 2 0002",
               a_done, a_pass, a_ready, a_cnt, a_sig);
    end else n_pass++;
  endtask

  task automatic test_feedback();
    golden  = 16'h1021;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_total++;
    if ({b_busy, b_sig} !== {1'b1, 16'h8000}) begin
      $display("FAIL feedback_seed: got busy=%b sig=%h, want 1 8000", b_busy, b_sig);
    end else n_pass++;
    resp_valid = 1'b1;
    resp       = 7'h00;
    tick();
    resp_valid = 1'b0;
    n_total++;
    if ({b_done, b_pass, b_busy, b_cnt, b_sig} !== {3'b110, 1'b1, 16'h1021}) begin
      $display("FAIL feedback: got done=%b pass=%b busy=%b cnt=%0d sig=%h, want 1 1 0 1 1021",
               b_done, b_pass, b_busy, b_cnt, b_sig);
    end else n_pass++;
  endtask

  task automatic test_midrun_reset();
    int exp;
    exp     = 0;
    golden  = 16'hffff;
    start_c = 1'b1;
    tick();
    start_c    = 1'b0;
    resp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      resp = 7'($urandom);
      exp  = misr_model(exp, int'(resp));
      tick();
    end
    resp_valid = 1'b0;
    n_total++;
    if ({c_cnt, c_sig} !== {14'd5, 16'(exp)}) begin
      $display("FAIL midrun_progress: got cnt=%0d sig=%h, want 5 %h", c_cnt, c_sig, 16'(exp));
    end else n_pass++;
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    n_total++;
    if ({c_busy, c_done, c_ready, c_cnt, c_sig} !== {3'b000, 14'd0, 16'h0000}) begin
      $display("FAIL midrun_abort: got busy=%b done=%b ready=%b cnt=%0d sig=%h, want 0 0 0 0 0000",
               c_busy, c_done, c_ready, c_cnt, c_sig);
    end else n_pass++;
    golden  = 16'h0002;
    start_a = 1'b1;
    tick();
    start_a    = 1'b0;
    resp_valid = 1'b1;
    resp       = 7'h01;
    tick();
    resp = 7'h00;
    tick();
    resp_valid = 1'b0;
    n_total++;
    if ({a_done, a_pass, a_cnt, a_sig, c_busy} !== {2'b11, 2'd2, 16'h0002, 1'b0}) begin
      $display("FAIL rerun_after_reset: got done=%b pass=%b cnt=%0d sig=%h c_busy=%b, want 1 1 2 0002 0",
               a_done, a_pass, a_cnt, a_sig, c_busy);
    end else n_pass++;
  endtask

  task automatic test_random_gaps();
    logic [6:0] words[10000];
    int exp;
    int idx;
    int cyc;
    int early;
    exp = 0;
    for (int i = 0; i < 10000; i++) begin
      words[i] = 7'($urandom);
      exp      = misr_model(exp, int'(words[i]));
    end
    golden  = 16'(exp);
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    golden  = ~golden;
    idx   = 0;
    cyc   = 0;
    early = 0;
    while (idx < 10000 && cyc < 60000) begin
      resp_valid = ($urandom_range(0, 2) != 0);
      resp       = resp_valid ? words[idx] : 7'($urandom);
      tick();
      if (resp_valid) idx++;
      if (idx < 10000 && c_done) early++;
      cyc++;
    end
    resp_valid = 1'b0;
    n_total++;
    if (idx !== 10000) begin
      $display("FAIL gaps_timeout: accepted %0d of 10000 within cycle budget", idx);
    end else n_pass++;
    n_total++;
    if (early !== 0) begin
      $display("FAIL gaps_early_done: done high on %0d cycles before last acceptance, want 0", early);
    end else n_pass++;
    n_total++;
    if ({c_done, c_pass, c_busy, c_cnt, c_sig} !== {3'b110, 14'd10000, 16'(exp)}) begin
      $display("FAIL gaps_result: got done=%b pass=%b busy=%b cnt=%0d sig=%h, want 1 1 0 10000 %h",
               c_done, c_pass, c_busy, c_cnt, c_sig, 16'(exp));
    end else n_pass++;
    resp_valid = 1'b1;
    tick();
    tick();
    resp_valid = 1'b0;
    n_total++;
    if ({c_done, c_cnt, c_sig} !== {1'b1, 14'd10000, 16'(exp)}) begin
      $display("FAIL gaps_count_stops: got done=%b cnt=%0d sig=%h, want 1 10000 %h",
               c_done, c_cnt, c_sig, 16'(exp));
    end else n_pass++;
  endtask

  initial begin
    rst_n      = 1'b0;
    golden     = '0;
    resp_valid = 1'b0;
    resp       = '0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    start_c    = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_fail_hold();
    test_feedback();
    test_midrun_reset();
    test_random_gaps();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/resp_compactor.md
RESP_COMPACTOR -- requirements
Module: resp_compactor

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- OUTPUT_WIDTH, 7, width of one circuit-under-test response word.
- NUMBER_OF_TESTS, 10000, number of responses compacted per run.
- SIG_WIDTH, 16, signature register width; must be at least OUTPUT_WIDTH.
- POLY, 16'h1021, MISR feedback polynomial, leading x^SIG_WIDTH term implicit.
- SEED, 16'h0000, signature value loaded at start.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- start, input, 1, one-cycle pulse that begins a run.
- golden_sig, input, SIG_WIDTH, expected signature; sampled when start is accepted.
- resp_valid, input, 1, resp holds a valid response word.
- resp, input, OUTPUT_WIDTH, response word from the circuit under test (out bus).
- resp_ready, output, 1, compactor accepts resp this cycle.
- busy, output, 1, a run is in progress.
- done, output, 1, run complete; held until the next start or reset.
- pass, output, 1, final signature equals the captured golden value; valid while done=1.
- signature, output, SIG_WIDTH, current MISR contents.
- count, output, $clog2(NUMBER_OF_TESTS+1), number of responses accepted in this run.

Function
REQ-003 The block SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-004 In IDLE or DONE, start=1 SHALL do all of the following on the next edge: signature<=SEED, count<=0, capture golden_sig, done<=0, pass<=0, state<=RUN.
REQ-005 start SHALL be ignored while in RUN.
REQ-006 resp_ready SHALL be 1 exactly when state==RUN (combinational from state).
REQ-007 A response SHALL be accepted on an edge where resp_valid && resp_ready; with no acceptance, signature and count SHALL hold.
REQ-008 On acceptance, the signature SHALL update as signature <= {signature[SIG_WIDTH-2:0],1'b0} ^ (signature[SIG_WIDTH-1] ? POLY : 0) ^ zero-extended resp.
REQ-009 On acceptance, count SHALL increment by 1.
REQ-010 When the acceptance takes count to NUMBER_OF_TESTS, the same edge SHALL set state<=DONE and done<=1, and set pass to (updated signature == captured golden).
REQ-011 Once in DONE, count SHALL stop at NUMBER_OF_TESTS and never wrap.
REQ-012 The latency from the last acceptance to done=1 and pass valid SHALL be 1 clock edge.
REQ-013 busy SHALL equal (state==RUN).
REQ-014 In DONE, resp_valid SHALL be ignored, and signature and count SHALL hold until the next start.
REQ-015 Changes to golden_sig after start SHALL NOT affect pass.
REQ-016 resp_valid may toggle arbitrarily during RUN; gaps SHALL NOT alter the signature.
REQ-017 Start in the same cycle as resp_valid while in IDLE or DONE SHALL perform only the start action; that resp SHALL NOT be accepted.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, signature=SEED, count=0, done=0, pass=0, busy=0, resp_ready=0, captured golden=0.
REQ-019 Reset asserted mid-run SHALL abort the run with no done pulse; a new start is then required.
REQ-020 The first edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-021 Reset: apply rst_n=0 between edges -> all outputs take their REQ-018 values before the next edge, with signature=16'h0000.
REQ-022 NUMBER_OF_TESTS=2, golden=16'h0002, start, then resp 7'h01 followed by 7'h00 -> signature 16'h0001 then 16'h0002; done=1, pass=1, count=2.
REQ-023 Same stimulus with golden=16'h0003 -> done=1, pass=0; signature holds 16'h0002 while resp_valid stays high in DONE.
REQ-024 Feedback: SEED=16'h8000, NUMBER_OF_TESTS=1, resp=7'h00 -> signature=16'h1021.
REQ-025 Gaps: default parameters, 10000 responses with random resp_valid gaps -> signature matches a reference model computing REQ-008 with no gaps; done rises exactly one edge after the 10000th acceptance.
REQ-026 Mid-run reset: reset after 5 acceptances -> IDLE, count=0; start then 2 responses (NUMBER_OF_TESTS=2) -> same result as REQ-022.
